load_store_unit: RTL and testbench

//  Memory-access stage directly downstream of the ALU: takes the ALU result as the effective address
//  and executes RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a req/ack data-memory port.

---
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-lane steering, strobes, extension,
// misalignment and bus-timeout handling over a req/ack memory port.
// Ports: clk, rst_n; request lsu_valid/is_load/is_store/funct3/addr/store_data;
// status lsu_busy/lsu_done/lsu_misaligned/lsu_bus_err/load_data;
// bus mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb/mem_ack/mem_rdata.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_misaligned,
  output logic        lsu_bus_err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [2:0]  f3_q;
  logic        ld_q;
  logic        mis_q;
  logic        err_q;
  logic [31:0] cnt;

  logic        accept;
  logic        bad;
  logic        mis;
  logic        timed_out;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;

  assign accept = lsu_valid && (is_load || is_store);

  // Unsupported encoding takes priority over misalignment.
  always_comb begin
    bad = 1'b0;
    mis = 1'b0;
    if (is_load)
      bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    else
      bad = funct3[2] || (funct3[1:0] == 2'b11);
    case (funct3[1:0])
      2'b01:   mis = addr[0];
      2'b10:   mis = |addr[1:0];
      default: mis = 1'b0;
    endcase
    mis = mis && !bad;
  end

  assign timed_out = (TIMEOUT_CYCLES != 0)
                  && (cnt == TIMEOUT_CYCLES - 1);

  always_comb begin
    strb  = 4'b1111;
    wdata = data_q;
    case (f3_q[1:0])
      2'b00: begin
        strb  = 4'b0001 << addr_q[1:0];
        wdata = {4{data_q[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << addr_q[1:0];
        wdata = {2{data_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rbyte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    rbyte = mem_rdata[15:8];
      2'd2:    rbyte = mem_rdata[23:16];
      2'd3:    rbyte = mem_rdata[31:24];
      default: rbyte = mem_rdata[7:0];
    endcase
    rhalf = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext   = mem_rdata;
    unique case (1'b1)
      (f3_q == 3'b000): ext = {{24{rbyte[7]}}, rbyte};
      (f3_q == 3'b001): ext = {{16{rhalf[15]}}, rhalf};
      (f3_q == 3'b100): ext = {24'd0, rbyte};
      (f3_q == 3'b101): ext = {16'd0, rhalf};
      default:          ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      f3_q      <= '0;
      ld_q      <= 1'b0;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= '0;
      load_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q <= addr;
            data_q <= store_data;
            f3_q   <= funct3;
            ld_q   <= is_load;
            mis_q  <= mis;
            err_q  <= bad;
            cnt    <= '0;
            state  <= (mis || bad) ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (ld_q) load_data <= ext;
            state <= S_DONE;
          end else if (timed_out) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lsu_busy       = state != S_IDLE;
  assign lsu_done       = state == S_DONE;
  assign lsu_misaligned = lsu_done && mis_q;
  assign lsu_bus_err    = lsu_done && err_q;
  assign mem_req        = state == S_REQ;
  assign mem_we         = mem_req && !ld_q;
  assign mem_addr       = {addr_q[31:2], 2'b00};
  assign mem_wdata      = wdata;
  assign mem_wstrb      = mem_we ? strb : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES=4).
// Hand-computed expectations, immediate-assertion checks.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        lsu_busy, lsu_done, lsu_misaligned, lsu_bus_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .is_load(is_load),
    .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done),
    .lsu_misaligned(lsu_misaligned),
    .lsu_bus_err(lsu_bus_err),
    .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns in cycle 1.
  task automatic issue(input logic ld, input logic st,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] d);
    lsu_valid  = 1'b1;
    is_load    = ld;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = d;
    tick();
    lsu_valid  = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
  endtask

  // Ack in the current REQ cycle; returns in DONE cycle.
  task automatic ack(input logic [31:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #1;
    chk("rst_busy", 32'(lsu_busy), 32'd0);
    chk("rst_done", 32'(lsu_done), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_strb", 32'(mem_wstrb), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // SW, ack on third REQ cycle
    issue(1'b0, 1'b1, 3'b010, 32'h1004, 32'hDEADBEEF);
    chk("sw_req", 32'(mem_req), 32'd1);
    chk("sw_busy", 32'(lsu_busy), 32'd1);
    chk("sw_addr", mem_addr, 32'h1004);
    chk("sw_we", 32'(mem_we), 32'd1);
    chk("sw_strb", 32'(mem_wstrb), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    tick();
    chk("sw_req3", 32'(mem_req), 32'd1);
    chk("sw_done3", 32'(lsu_done), 32'd0);
    ack(32'h0);
    chk("sw_done4", 32'(lsu_done), 32'd1);
    chk("sw_req4", 32'(mem_req), 32'd0);
    chk("sw_err4", 32'(lsu_bus_err), 32'd0);
    tick();
    chk("sw_idle", 32'(lsu_busy), 32'd0);

    // LB / LBU / LHU
    issue(1'b1, 1'b0, 3'b000, 32'h2003, 32'h0);
    chk("lb_addr", mem_addr, 32'h2000);
    chk("lb_we", 32'(mem_we), 32'd0);
    chk("lb_strb", 32'(mem_wstrb), 32'd0);
    ack(32'h80FF1234);
    chk("lb_done", 32'(lsu_done), 32'd1);
    chk("lb_data", load_data, 32'hFFFFFF80);
    tick();
    issue(1'b1, 1'b0, 3'b100, 32'h2003, 32'h0);
    ack(32'h80FF1234);
    chk("lbu_data", load_data, 32'h00000080);
    tick();
    issue(1'b1, 1'b1, 3'b101, 32'h2002, 32'h0);
    chk("lhu_we", 32'(mem_we), 32'd0);
    ack(32'h80FF1234);
    chk("lhu_data", load_data, 32'h000080FF);
    tick();

    // SH
    issue(1'b0, 1'b1, 3'b001, 32'h3002, 32'h0000ABCD);
    chk("sh_addr", mem_addr, 32'h3000);
    chk("sh_wdata", mem_wdata, 32'hABCDABCD);
    chk("sh_strb", 32'(mem_wstrb), 32'hC);
    ack(32'h0);
    tick();

    // SB
    issue(1'b0, 1'b1, 3'b000, 32'h7001, 32'h123456A5);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("sb_strb", 32'(mem_wstrb), 32'h2);
    ack(32'h0);
    tick();

    // Misaligned LH
    issue(1'b1, 1'b0, 3'b001, 32'h2001, 32'h0);
    chk("mis_done", 32'(lsu_done), 32'd1);
    chk("mis_flag", 32'(lsu_misaligned), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_ld", load_data, 32'h000080FF);
    tick();
    chk("mis_idle", 32'(lsu_busy), 32'd0);

    // Unsupported load funct3
    issue(1'b1, 1'b0, 3'b011, 32'h2000, 32'h0);
    chk("bad_done", 32'(lsu_done), 32'd1);
    chk("bad_err", 32'(lsu_bus_err), 32'd1);
    chk("bad_mis", 32'(lsu_misaligned), 32'd0);
    tick();

    // valid without a kind is ignored
    issue(1'b0, 1'b0, 3'b010, 32'h2000, 32'h0);
    chk("nokind", 32'(lsu_busy), 32'd0);

    // Timeout
    issue(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), 32'(mem_req), 32'd1);
      tick();
    end
    chk("to_done", 32'(lsu_done), 32'd1);
    chk("to_err", 32'(lsu_bus_err), 32'd1);
    chk("to_req", 32'(mem_req), 32'd0);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("late_busy", 32'(lsu_busy), 32'd0);
    chk("late_done", 32'(lsu_done), 32'd0);
    chk("to_ld", load_data, 32'h000080FF);

    // Reset mid-access
    issue(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0);
    chk("ra_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ra_req0", 32'(mem_req), 32'd0);
    chk("ra_busy0", 32'(lsu_busy), 32'd0);
    tick();
    chk("ra_done", 32'(lsu_done), 32'd0);
    chk("ra_ld", load_data, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ra_done2", 32'(lsu_done), 32'd0);
    issue(1'b1, 1'b0, 3'b010, 32'h6008, 32'h0);
    chk("ra_addr", mem_addr, 32'h6008);
    ack(32'h12345678);
    chk("ra_lwdone", 32'(lsu_done), 32'd1);
    chk("ra_lw", load_data, 32'h12345678);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
